// File: rtl/iterative_muldiv_unit.sv
// iterative_muldiv_unit
//   Radix-2 multi-cycle multiply/divide engine, one product/quotient bit per clock.
//   MUL returns the full 2*WIDTH product; DIV returns quotient and remainder.
//   Signed mode works on magnitudes and applies a sign fix-up at completion.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   flush_i                synchronous abort (results untouched)
//   start_i                request, accepted when not busy
//   op_i                   0 = MUL, 1 = DIV
//   signed_mode_i          two's-complement operands (ignored when SIGNED_EN=0)
//   operand_a_i/_b_i       multiplicand/dividend, multiplier/divisor
//   busy_o                 high while iterating
//   done_o                 one-cycle completion pulse
//   result_o               MUL: product low half, DIV: quotient
//   result_hi_o            MUL: product high half, DIV: remainder
//   div_by_zero_o          DIV with zero divisor, held with the result
module iterative_muldiv_unit #(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Per-operation control latched at acceptance.
    typedef struct packed {
        logic op;
        logic neg_q;   // MUL: negate product, DIV: negate quotient
        logic neg_r;   // DIV: negate remainder (sign of dividend)
    } ctl_t;

    state_t           state_q;
    ctl_t             ctl_q, ctl_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             dz_pend_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] res_q, res_hi_q;

    // Operand magnitudes at acceptance
    logic             sgn_en, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign sgn_en = (SIGNED_EN != 0) && signed_mode_i;
    assign a_neg  = sgn_en & operand_a_i[WIDTH-1];
    assign b_neg  = sgn_en & operand_b_i[WIDTH-1];
    assign mag_a  = a_neg ? -operand_a_i : operand_a_i;
    assign mag_b  = b_neg ? -operand_b_i : operand_b_i;

    always_comb begin
        ctl_d       = '0;
        ctl_d.op    = op_i;
        ctl_d.neg_q = a_neg ^ b_neg;
        ctl_d.neg_r = a_neg;
    end

    // One iteration step.
    // MUL: hi_q:lo_q is the 2*WIDTH accumulator, lo_q starts as the multiplier and
    //      is shifted out LSB first while the product shifts in from the top.
    // DIV: hi_q holds the restored partial remainder (always < divisor), lo_q starts
    //      as the dividend and is shifted out MSB first while quotient bits shift in.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_d, mul_lo_d;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               qbit;
    logic [WIDTH-1:0]   div_hi_d, div_lo_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               unused_trial_msb;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});
        mul_hi_d  = mul_sum[WIDTH:1];
        mul_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};

        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        qbit      = (div_shift >= {1'b0, opnd_q});
        div_hi_d  = qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_d  = {lo_q[WIDTH-2:0], qbit};

        prod_fix  = ctl_q.neg_q ? -{mul_hi_d, mul_lo_d} : {mul_hi_d, mul_lo_d};
        quot_fix  = ctl_q.neg_q ? -div_lo_d : div_lo_d;
        rem_fix   = ctl_q.neg_r ? -div_hi_d : div_hi_d;
    end

    // Trial difference MSB is never needed: when kept, the difference is < divisor.
    assign unused_trial_msb = div_trial[WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ctl_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            res_q     <= '0;
            res_hi_q  <= '0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (ctl_q.op) begin
                        hi_q <= div_hi_d;
                        lo_q <= div_lo_d;
                    end else begin
                        hi_q <= mul_hi_d;
                        lo_q <= mul_lo_d;
                    end
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        if (ctl_q.op) begin
                            res_q    <= quot_fix;
                            res_hi_q <= rem_fix;
                        end else begin
                            res_q    <= prod_fix[WIDTH-1:0];
                            res_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: begin  // IDLE, DONE
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (dz_pend_q) begin
                        // Divide by zero completes one edge after acceptance without
                        // entering CALC; the raw dividend was parked in lo_q.
                        dz_pend_q <= 1'b0;
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        dbz_q     <= 1'b1;
                        res_q     <= '1;
                        res_hi_q  <= lo_q;
                    end else if (start_i) begin
                        ctl_q <= ctl_d;
                        cnt_q <= '0;
                        if (op_i && (operand_b_i == '0)) begin
                            dz_pend_q <= 1'b1;
                            lo_q      <= operand_a_i;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            hi_q    <= '0;
                            opnd_q  <= op_i ? mag_b : mag_a;
                            lo_q    <= op_i ? mag_a : mag_b;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = res_q;
    assign result_hi_o   = res_hi_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
module tb_iterative_muldiv_unit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, flush, start, op, sm;
    logic [W-1:0] a, b;
    logic         busy, done, dbz;
    logic [W-1:0] res, res_hi;

    int errors = 0;
    int checks = 0;

    iterative_muldiv_unit #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start), .op_i(op),
        .signed_mode_i(sm), .operand_a_i(a), .operand_b_i(b),
        .busy_o(busy), .done_o(done), .result_o(res), .result_hi_o(res_hi),
        .div_by_zero_o(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural meaning of each op.
    function automatic void model(input logic mop, input logic msm,
                                  input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] r, output logic [W-1:0] rh,
                                  output logic dz);
        longint p;
        int     q, m;
        dz = 1'b0;
        if (!mop) begin
            if (msm) p = longint'($signed(ma)) * longint'($signed(mb));
            else     p = longint'(ma) * longint'(mb);
            r  = p[15:0];
            rh = p[31:16];
        end else if (mb == 0) begin
            r  = 16'hFFFF;
            rh = ma;
            dz = 1'b1;
        end else begin
            if (msm) begin
                q = int'($signed(ma)) / int'($signed(mb));
                m = int'($signed(ma)) % int'($signed(mb));
            end else begin
                q = int'(ma) / int'(mb);
                m = int'(ma) % int'(mb);
            end
            r  = q[15:0];
            rh = m[15:0];
        end
    endfunction

    // Drive one request so it is accepted at the next rising edge; returns #1 after it.
    task automatic start_op(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; sm = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges from acceptance until done is seen, and samples with busy high.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, seen;
        logic [W-1:0] er, erh;
        logic edz;

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 1'b0; sm = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, busy, done, dbz, res_hi, res}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Unsigned MUL with latency and busy duration
        start_op(1'b0, 1'b0, 16'h00FF, 16'h0101);
        wait_done(lat, bc);
        check("mul_u_latency", lat, 16);
        check("mul_u_busy_cycles", bc, 16);
        check("mul_u_result", {res_hi, res}, 32'h0000_FFFF);
        check("mul_u_dbz", dbz, 0);

        start_op(1'b0, 1'b1, 16'hFFFD, 16'h0005);
        wait_done(lat, bc);
        check("mul_s_result", {res_hi, res}, 32'hFFFF_FFF1);

        start_op(1'b0, 1'b0, 16'hFFFD, 16'h0005);
        wait_done(lat, bc);
        check("mul_u_big_result", {res_hi, res}, 32'h0004_FFF1);

        start_op(1'b1, 1'b0, 16'd100, 16'd7);
        wait_done(lat, bc);
        check("div_u_latency", lat, 16);
        check("div_u_result", {res_hi, res}, 32'h0002_000E);

        start_op(1'b1, 1'b1, 16'hFF9C, 16'h0007);
        wait_done(lat, bc);
        check("div_s_result", {res_hi, res}, 32'hFFFE_FFF2);

        // Divide by zero
        start_op(1'b1, 1'b0, 16'h04D2, 16'h0000);
        wait_done(lat, bc);
        check("dz_latency", lat, 1);
        check("dz_busy_cycles", bc, 0);
        check("dz_result", {res_hi, res}, 32'h04D2_FFFF);
        check("dz_flag", dbz, 1);
        @(posedge clk); #1;
        check("dz_done_pulse", done, 0);
        check("dz_flag_held", dbz, 1);
        start_op(1'b0, 1'b0, 16'd3, 16'd4);
        wait_done(lat, bc);
        check("dz_cleared", {dbz, res_hi, res}, {1'b0, 32'h0000_000C});

        // Signed overflow
        start_op(1'b1, 1'b1, 16'h8000, 16'hFFFF);
        wait_done(lat, bc);
        check("div_ovf_result", {dbz, res_hi, res}, {1'b0, 32'h0000_8000});

        // start during CALC is ignored
        start_op(1'b0, 1'b0, 16'h1234, 16'h0010);
        repeat (3) @(posedge clk);
        #1;
        op = 1'b1; a = 16'h0055; b = 16'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("ignore_start_latency", lat, 12);
        check("ignore_start_result", {res_hi, res}, 32'h0001_2340);
        repeat (2) @(posedge clk);
        #1;
        check("ignore_start_no_rerun", {busy, done}, 2'b00);

        // flush mid-iteration
        start_op(1'b0, 1'b0, 16'h00FF, 16'h0002);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_drop", {busy, done}, 2'b00);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("flush_no_done", seen, 0);
        check("flush_result_held", {res_hi, res}, 32'h0001_2340);

        // flush in the same cycle as start drops the request
        @(negedge clk);
        op = 1'b0; sm = 1'b0; a = 16'd9; b = 16'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("flush_drops_start", {busy, done, res_hi, res}, {2'b00, 32'h0001_2340});

        // Back-to-back start in DONE
        start_op(1'b0, 1'b0, 16'd7, 16'd6);
        wait_done(lat, bc);
        check("b2b_first", {res_hi, res}, 32'd42);
        op = 1'b1; sm = 1'b0; a = 16'd1000; b = 16'd33; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("b2b_latency", lat, 16);
        check("b2b_second", {res_hi, res}, {16'd10, 16'd30});

        // Async reset mid-CALC
        start_op(1'b0, 1'b0, 16'h0F0F, 16'h00F0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_calc", {29'd0, busy, done, dbz, res_hi, res}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic ro, rs;
            logic [W-1:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 16'h8000;
                2: rb = 16'hFFFF;
                3: rb = 16'h0001;
                default: ;
            endcase
            model(ro, rs, ra, rb, er, erh, edz);
            start_op(ro, rs, ra, rb);
            wait_done(lat, bc);
            check($sformatf("rand%0d_lat op=%0d a=%h b=%h", i, ro, ra, rb),
                  lat, (ro && rb == 0) ? 1 : 16);
            check($sformatf("rand%0d_res op=%0d s=%0d a=%h b=%h", i, ro, rs, ra, rb),
                  {dbz, res_hi, res}, {edz, erh, er});
            if ($urandom_range(0, 1) == 1) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
